// File: rtl/ysyx_24100005_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100005_pkg
// Description : Shared types and constants for the IFU/LSU memory arbiter:
//               FSM state encoding, requester ids and watchdog default.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24100005_pkg;

  // Arbiter FSM states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_t;

  // Requester ids, also used as the owner / last-grant encoding
  localparam logic c_ID_IFU = 1'b0;
  localparam logic c_ID_LSU = 1'b1;

  // Default response watchdog limit in WAIT cycles (legal range 1..255)
  localparam int c_TIMEOUT_DEFAULT = 255;

  // Width of the watchdog counter
  localparam int c_WD_W = 8;

endpackage
`default_nettype wire

// File: rtl/ysyx_24100005_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100005_rr_arb2
// Description : Two-way round-robin grant. A single valid requester wins
//               outright; on a tie the requester that was not granted last
//               time wins. Purely combinational, one-hot (or zero) grant.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100005_rr_arb2
  import ysyx_24100005_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // Tie goes to the requester other than last_grant
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (last_grant == c_ID_LSU) ? 2'b01 : 2'b10;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24100005_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_24100005_mem_arbiter
// Description : Arbitrates IFU (m0) and LSU (m1) onto one shared memory port
//               with a single outstanding transaction, round-robin grants,
//               combinational response pass-through and a response watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24100005_mem_arbiter
  import ysyx_24100005_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = c_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  // requester 0 (IFU)
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_wen,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [7:0]        m0_wmask,
  output logic              m0_resp_valid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_resp_err,
  // requester 1 (LSU)
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_wen,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [7:0]        m1_wmask,
  output logic              m1_resp_valid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_resp_err,
  // shared memory port
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Watchdog fires when the cycle being counted is the TIMEOUT-th WAIT cycle
  // without a response, i.e. when the counter already holds TIMEOUT-1.
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic              r_last_grant;
  logic              r_owner;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wmask;
  logic [c_WD_W-1:0] r_wd_cnt;

  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_resp;
  logic              w_timeout;

  ysyx_24100005_rr_arb2 u_rr_arb2 (
    .valid      ({m1_req_valid, m0_req_valid}),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state, handshake and response outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_resp        = 1'b0;
    w_timeout     = 1'b0;
    mem_req_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        // Ready is withheld while reset is asserted even though the grant is live
        if ((w_grant != 2'b00) && !rst) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A real response in the watchdog cycle takes precedence over the timeout
        if (mem_resp_valid) begin
          w_resp      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_wd_cnt == c_WD_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    m0_req_ready  = w_accept && w_grant[0];
    m1_req_ready  = w_accept && w_grant[1];
    m0_resp_valid = (w_resp || w_timeout) && (r_owner == c_ID_IFU);
    m1_resp_valid = (w_resp || w_timeout) && (r_owner == c_ID_LSU);
    m0_resp_err   = w_timeout && (r_owner == c_ID_IFU);
    m1_resp_err   = w_timeout && (r_owner == c_ID_LSU);
    m0_rdata      = (w_resp && (r_owner == c_ID_IFU)) ? mem_rdata : '0;
    m1_rdata      = (w_resp && (r_owner == c_ID_LSU)) ? mem_rdata : '0;
  end

  // Capture the granted request and its owner on acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= c_ID_LSU;
      r_owner      <= c_ID_IFU;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else if (w_accept) begin
      r_last_grant <= w_grant[1];
      r_owner      <= w_grant[1];
      r_addr       <= w_grant[1] ? m1_addr  : m0_addr;
      r_wen        <= w_grant[1] ? m1_wen   : m0_wen;
      r_wdata      <= w_grant[1] ? m1_wdata : m0_wdata;
      r_wmask      <= w_grant[1] ? m1_wmask : m0_wmask;
    end
  end

  // Watchdog: held at zero outside WAIT, counts WAIT cycles with no response
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_wd_cnt <= '0;
    else if (r_state != ST_WAIT)  r_wd_cnt <= '0;
    else if (!mem_resp_valid)     r_wd_cnt <= r_wd_cnt + 1'b1;
  end

  assign mem_addr  = r_addr;
  assign mem_wen   = r_wen;
  assign mem_wdata = r_wdata;
  assign mem_wmask = r_wmask;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24100005_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_24100005_mem_arbiter
// Description : Self-checking bench for the IFU/LSU memory arbiter. Expected
//               responses are queued when a grant is predicted and popped when
//               the arbiter returns a response.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24100005_mem_arbiter;

  localparam int c_TO = 4;

  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req_valid = 0, m1_req_valid = 0;
  logic        m0_req_ready, m1_req_ready;
  logic [31:0] m0_addr = 0, m1_addr = 0;
  logic        m0_wen = 0, m1_wen = 0;
  logic [31:0] m0_wdata = 0, m1_wdata = 0;
  logic [7:0]  m0_wmask = 8'hFF, m1_wmask = 8'hFF;
  logic        m0_resp_valid, m1_resp_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_resp_err, m1_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_resp_valid = 0;
  logic [31:0] mem_rdata = 0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic m_last = 1'b1;

  always #5 clk = ~clk;

  ysyx_24100005_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(c_TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_resp_valid(m0_resp_valid), .m0_rdata(m0_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_resp_valid(m1_resp_valid), .m1_rdata(m1_rdata), .m1_resp_err(m1_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  // Reference round-robin choice
  function automatic logic [1:0] exp_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    return {v1, v0};
  endfunction

  // One full transaction starting in IDLE: grant, optional memory stall,
  // then either a response after `lat` WAIT cycles or a watchdog timeout.
  task automatic run_txn(input logic v0, input logic v1, input int stall, input int lat,
                         input logic [31:0] rdata, input bit to_exp);
    logic [1:0]  g;
    logic        own;
    exp_t        e;
    logic [31:0] ea, ed, s0a, s1a, got_rd;
    logic        ew, got_err;
    logic [7:0]  em;
    int          nwait;
    @(negedge clk);
    m0_req_valid = v0; m1_req_valid = v1; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    g = exp_grant(v0, v1, m_last);
    n_checks++;
    if ({m1_req_ready, m0_req_ready} !== g || mem_req_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL grant: ready={m1,m0}=%b mem_req_valid=%b, expected %b and 0",
               {m1_req_ready, m0_req_ready}, mem_req_valid, g);
    end
    own = g[1];
    m_last = own;
    ea = own ? m1_addr : m0_addr;
    ew = own ? m1_wen : m0_wen;
    ed = own ? m1_wdata : m0_wdata;
    em = own ? m1_wmask : m0_wmask;
    e.id = own; e.rdata = to_exp ? 32'h0 : rdata; e.err = to_exp;
    sb.push_back(e);
    s0a = m0_addr; s1a = m1_addr;
    @(posedge clk);
    #1 m0_addr = ~s0a; m1_addr = ~s1a;   // latched copy must not follow the inputs
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      mem_req_ready = (i == stall);
      #1;
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== ea || mem_wen !== ew || mem_wdata !== ed ||
          mem_wmask !== em || m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0 ||
          m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL req_phase[%0d]: valid=%b addr=%h wen=%b wdata=%h wmask=%h rdy=%b%b, expected 1 %h %b %h %h 00",
                 i, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
                 m1_req_ready, m0_req_ready, ea, ew, ed, em);
      end
      @(posedge clk);
    end
    nwait = to_exp ? c_TO : lat + 1;
    for (int i = 0; i < nwait; i++) begin
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = !to_exp && (i == lat);
      mem_rdata      = mem_resp_valid ? rdata : 32'hA5A5_5A5A;
      #1;
      n_checks++;
      if (i == nwait - 1) begin
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL scoreboard_empty: no expected response queued");
        end else begin
          e = sb.pop_front();
          got_rd  = e.id ? m1_rdata : m0_rdata;
          got_err = e.id ? m1_resp_err : m0_resp_err;
          if (m0_resp_valid !== (e.id == 1'b0) || m1_resp_valid !== (e.id == 1'b1) ||
              got_rd !== e.rdata || got_err !== e.err || mem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL response: resp_valid={m1,m0}=%b%b rdata=%h err=%b, expected owner m%0d rdata=%h err=%b",
                     m1_resp_valid, m0_resp_valid, got_rd, got_err, e.id, e.rdata, e.err);
          end
        end
      end else if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL wait[%0d]: resp_valid={m1,m0}=%b%b mem_req_valid=%b, expected 0",
                 i, m1_resp_valid, m0_resp_valid, mem_req_valid);
      end
      @(posedge clk);
    end
    #1 mem_resp_valid = 1'b0;
    m0_addr = s0a; m1_addr = s1a;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (m0_req_ready !== 1'b0 || m1_req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_ready: ready={m1,m0}=%b%b, expected 00", m1_req_ready, m0_req_ready);
    end
    n_checks++;
    if (mem_req_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wen !== 1'b0 ||
        mem_wdata !== 32'h0 || mem_wmask !== 8'h0) begin
      n_errors++;
      $display("FAIL reset_mem: valid=%b addr=%h wen=%b wdata=%h wmask=%h, expected all 0",
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask);
    end
    n_checks++;
    if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0 || m0_rdata !== 32'h0 ||
        m1_rdata !== 32'h0 || m0_resp_err !== 1'b0 || m1_resp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_resp: valid=%b%b rdata=%h/%h err=%b%b, expected all 0",
               m1_resp_valid, m0_resp_valid, m1_rdata, m0_rdata, m1_resp_err, m0_resp_err);
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
  endtask

  task automatic test_both_at_release();
    @(posedge clk);
    #1 rst = 1'b0;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    m0_addr = 32'h8000_0000; m1_addr = 32'h8000_0004;
    run_txn(1'b1, 1'b1, 0, 0, 32'h1122_3344, 1'b0);   // m0 first
    run_txn(1'b1, 1'b1, 0, 0, 32'h5566_7788, 1'b0);   // then m1
  endtask

  task automatic test_alternate();
    for (int k = 0; k < 4; k++) begin
      m0_addr = 32'h8000_0100 + 32'(k * 8);
      m1_addr = 32'h8000_0200 + 32'(k * 8);
      run_txn(1'b1, 1'b1, 0, k % 2, 32'hC0DE_0000 + 32'(k), 1'b0);
    end
  endtask

  task automatic test_stall();
    m0_addr = 32'h8000_0010; m1_addr = 32'h8000_0020;
    run_txn(1'b1, 1'b1, 5, 1, 32'h0102_0304, 1'b0);
  endtask

  task automatic test_timeout();
    m0_addr = 32'h8000_0030;
    run_txn(1'b1, 1'b0, 0, 0, 32'h0, 1'b1);            // watchdog expires
    run_txn(1'b1, 1'b0, 0, c_TO - 1, 32'h7777_8888, 1'b0); // response in watchdog cycle wins
  endtask

  task automatic test_write();
    m1_addr = 32'h8000_1000; m1_wen = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wmask = 8'h0F;
    run_txn(1'b0, 1'b1, 0, 2, 32'h0000_0000, 1'b0);
    m1_wen = 1'b0; m1_wdata = 32'h0; m1_wmask = 8'hFF;
  endtask

  task automatic test_reset_mid_txn();
    @(negedge clk);
    m0_req_valid = 1'b0; m1_req_valid = 1'b1; m1_addr = 32'h8000_2000; #1;
    n_checks++;
    if (m1_req_ready !== 1'b1 || m0_req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_grant: ready={m1,m0}=%b%b, expected 10", m1_req_ready, m0_req_ready);
    end
    @(posedge clk); #1 m1_req_valid = 1'b0;
    @(negedge clk); mem_req_ready = 1'b1; #1;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h8000_2000) begin
      n_errors++;
      $display("FAIL midrst_req: valid=%b addr=%h, expected 1 80002000", mem_req_valid, mem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    mem_req_ready = 1'b0; rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; #1;
    n_checks++;
    if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || mem_addr !== 32'h0) begin
      n_errors++;
      $display("FAIL midrst_abandon: resp_valid=%b%b mem_req_valid=%b addr=%h, expected 0 0 0 0",
               m1_resp_valid, m0_resp_valid, mem_req_valid, mem_addr);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (m0_resp_valid !== 1'b0 || m1_resp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_stale: resp_valid={m1,m0}=%b%b, expected 00", m1_resp_valid, m0_resp_valid);
    end
    mem_resp_valid = 1'b0;
    m_last = 1'b1;
    m0_addr = 32'h8000_3000; m1_addr = 32'h8000_3004;
    run_txn(1'b1, 1'b1, 0, 0, 32'h0BAD_F00D, 1'b0);   // m0 priority again
  endtask

  initial begin
    test_reset();
    test_both_at_release();
    test_alternate();
    test_stall();
    test_timeout();
    test_write();
    test_reset_mid_txn();
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
